// File: rtl/cmd_exec_sched.sv
// Command scheduler: waits for start time, emits N impulses (Ti wide, Tp period), then requests the next command.
// Latency: IMP rises one edge after TIME >= start is sampled; no backpressure, DATA_WR while busy goes to a one-deep pending slot.
module cmd_exec_sched #(
    parameter int REQ_LEN = 4,
    parameter bit PEND_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic [63:0] TIME,
    input  logic        DATA_WR,
    input  logic [63:0] TIME_START,
    input  logic [15:0] N_impuls,
    input  logic [31:0] Interval_Ti,
    input  logic [31:0] Interval_Tp,
    input  logic        CMD_SEARCH_FAULT,
    output logic        REQ_COMM,
    output logic        IMP,
    output logic        BUSY,
    output logic        CMD_LATE,
    output logic [15:0] IMP_CNT,
    output logic [2:0]  STATE
);

    localparam int CW = $clog2(REQ_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_RUN  = 3'd2,
        S_REQ  = 3'd3
    } state_t;

    state_t state, state_nxt;

    logic [63:0]   act_start, pend_start;
    logic [15:0]   act_n, pend_n;
    logic [31:0]   act_ti, act_tp, pend_ti, pend_tp;
    logic          pend_v;
    logic [31:0]   per_cnt;
    logic [CW-1:0] req_cnt;

    logic [31:0] tp_in, ti_in;
    logic        late_in, late_pend, load_act, load_pend, xfer;
    logic        run_go, per_end, train_done, req_hold;

    always_comb begin
        tp_in      = (Interval_Tp == 32'd0) ? 32'd1 : Interval_Tp;
        ti_in      = (Interval_Ti > tp_in) ? tp_in : Interval_Ti;
        late_in    = (TIME_START <= TIME);
        late_pend  = (pend_start <= TIME);
        load_act   = DATA_WR && (state == S_IDLE || state == S_REQ);
        load_pend  = DATA_WR && PEND_EN && (state == S_WAIT || state == S_RUN);
        // A pending command is only picked up on the first REQ cycle, before any request goes out.
        xfer       = (state == S_REQ) && !DATA_WR && !REQ_COMM && pend_v;
        run_go     = (state == S_WAIT) && (TIME >= act_start) && (act_n != 16'd0);
        per_end    = (per_cnt == act_tp - 32'd1);
        train_done = per_end && (IMP_CNT >= act_n);
        req_hold   = (state == S_REQ) && !DATA_WR && !pend_v && (REQ_COMM || !CMD_SEARCH_FAULT);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (DATA_WR) state_nxt = late_in ? S_REQ : S_WAIT;
            S_WAIT: if (TIME >= act_start) state_nxt = (act_n == 16'd0) ? S_REQ : S_RUN;
            S_RUN:  if (train_done) state_nxt = S_REQ;
            S_REQ: begin
                if (DATA_WR)                              state_nxt = late_in ? S_REQ : S_WAIT;
                else if (xfer)                            state_nxt = late_pend ? S_REQ : S_WAIT;
                else if (!REQ_COMM && CMD_SEARCH_FAULT)   state_nxt = S_IDLE;
                else if (REQ_COMM && req_cnt == CW'(REQ_LEN)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUSY  = (state != S_IDLE);
        STATE = state;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            act_start  <= '0;
            act_n      <= '0;
            act_ti     <= '0;
            act_tp     <= 32'd1;
            pend_start <= '0;
            pend_n     <= '0;
            pend_ti    <= '0;
            pend_tp    <= 32'd1;
            pend_v     <= 1'b0;
            per_cnt    <= '0;
            req_cnt    <= '0;
            IMP_CNT    <= '0;
            IMP        <= 1'b0;
            REQ_COMM   <= 1'b0;
            CMD_LATE   <= 1'b0;
        end else begin
            if (load_act) begin
                act_start <= TIME_START;
                act_n     <= N_impuls;
                act_ti    <= ti_in;
                act_tp    <= tp_in;
                IMP_CNT   <= '0;
                CMD_LATE  <= late_in;
            end else if (xfer) begin
                act_start <= pend_start;
                act_n     <= pend_n;
                act_ti    <= pend_ti;
                act_tp    <= pend_tp;
                pend_v    <= 1'b0;
                IMP_CNT   <= '0;
                CMD_LATE  <= late_pend;
            end

            if (load_pend) begin
                pend_start <= TIME_START;
                pend_n     <= N_impuls;
                pend_ti    <= ti_in;
                pend_tp    <= tp_in;
                pend_v     <= 1'b1;
                CMD_LATE   <= 1'b0;
            end

            // IMP tracks the per_cnt value it is registered alongside.
            if (run_go) begin
                per_cnt <= '0;
                IMP_CNT <= 16'd1;
                IMP     <= (act_ti != 32'd0);
            end else if (state == S_RUN) begin
                if (per_end) begin
                    if (IMP_CNT < act_n) begin
                        per_cnt <= '0;
                        IMP_CNT <= IMP_CNT + 16'd1;
                        IMP     <= (act_ti != 32'd0);
                    end else begin
                        IMP <= 1'b0;
                    end
                end else begin
                    per_cnt <= per_cnt + 32'd1;
                    IMP     <= ((per_cnt + 32'd1) < act_ti);
                end
            end else begin
                IMP <= 1'b0;
            end

            if (req_hold) begin
                if (!REQ_COMM) begin
                    REQ_COMM <= 1'b1;
                    req_cnt  <= CW'(1);
                end else if (req_cnt == CW'(REQ_LEN)) begin
                    REQ_COMM <= 1'b0;
                end else begin
                    req_cnt <= req_cnt + CW'(1);
                end
            end else begin
                REQ_COMM <= 1'b0;
            end
        end
    end

endmodule

// File: doc/cmd_exec_sched.md
# cmd_exec_sched

Command execution scheduler between the command-memory writer and the impulse-forming logic. It accepts the command word strobed out of the command memory and waits until system time reaches the command start time. It then generates the programmed impulse train (N impulses, width Ti, period Tp, all in 48 MHz clock cycles). On completion it requests the next command from the memory, so it paces the whole command memory.

## Interface
Parameters:
- REQ_LEN, 4, number of cycles REQ_COMM is held high. Must be ≥3 because the memory side edge-detects it through a 3-stage shift register.
- PEND_EN, 1, enables the one-deep pending-command buffer. When 0, DATA_WR arriving while busy is dropped.

Ports:
- CLK  in  1  48 MHz system clock.
- rst_n  in  1  asynchronous, active-low reset.
- TIME  in  64  current system time, in clock ticks.
- DATA_WR  in  1  command strobe from the memory. Fields below are valid in the same cycle.
- TIME_START  in  64  absolute start time of the command.
- N_impuls  in  16  impulse count.
- Interval_Ti  in  32  impulse width, in cycles.
- Interval_Tp  in  32  impulse period, in cycles.
- CMD_SEARCH_FAULT  in  1  level; memory holds no executable command.
- REQ_COMM  out  1  next-command request. Reset 0.
- IMP  out  1  impulse gate. Reset 0.
- BUSY  out  1  high outside IDLE. Reset 0.
- CMD_LATE  out  1  sticky flag: last loaded command was already in the past. Reset 0.
- IMP_CNT  out  16  impulses started in the current command. Reset 0.
- STATE  out  3  state code: IDLE=0, WAIT=1, RUN=2, REQ=3. Reset 0.

## Operation
- Registers:
  - Active set: start, n, ti, tp.
  - Pending set: the same fields plus a pend_v bit.
  - Counters: per_cnt (32 bit) and IMP_CNT.
- Load rules:
  - DATA_WR in IDLE or REQ loads the active set.
  - DATA_WR in WAIT or RUN loads the pending set and sets pend_v, if PEND_EN=1. A newer pending write overwrites an older one.
  - Loading also clears CMD_LATE.
- Input normalisation on load:
  - tp = max(Interval_Tp, 1).
  - ti = min(Interval_Ti, tp).
- Late check on load: if TIME_START ≤ TIME (same-cycle sample), set CMD_LATE and go to REQ. Otherwise go to WAIT.
- N_impuls = 0: enter WAIT normally. At start time go directly to REQ; IMP stays 0.
- WAIT:
  - Compare TIME ≥ start every cycle. A system-time rewrite is therefore followed automatically.
  - On a true compare: go to RUN, per_cnt←0, IMP_CNT←1.
- RUN:
  - IMP = (per_cnt < ti), registered.
  - per_cnt increments every cycle.
  - When per_cnt = tp−1 and IMP_CNT < n: per_cnt←0, IMP_CNT+1.
  - When per_cnt = tp−1 and IMP_CNT = n: go to REQ, IMP←0.
- REQ:
  - If pend_v is set: transfer pending→active, clear pend_v, apply the late check, no request issued.
  - Else: drive REQ_COMM for REQ_LEN cycles, then go to IDLE.
  - Else if CMD_SEARCH_FAULT is high on entry: skip the request and go to IDLE.
- IDLE waits for DATA_WR.
- Counter wrap-around is impossible: counters are bounded by n and tp.

## Timing
- DATA_WR at edge k → STATE=WAIT (or REQ if late) visible after edge k.
- First rising edge of IMP: the first edge at which the sampled TIME ≥ start. IMP is high from that edge on; latency 1 cycle from the TIME sample.
- Impulse j (0-based) rises at t0 + j·tp and lasts exactly ti cycles. The train ends at t0 + n·tp, where IMP=0 and STATE=REQ.
- REQ_COMM rises 1 cycle after entering REQ and is high for exactly REQ_LEN cycles.
- DATA_WR arriving during REQ_COMM high: load takes precedence, REQ_COMM drops immediately, no second request.
- Asynchronous reset mid-operation: all outputs and registers go to their reset values immediately; pend_v=0; IMP drops without completing the impulse.

## Test plan
- TIME=1000, DATA_WR with TIME_START=1100, N=3, Ti=10, Tp=50:
  - IMP high for 10 cycles starting at TIME=1100, 1150, 1200.
  - IMP_CNT ends at 3.
  - REQ_COMM high for 4 cycles starting at TIME=1251.
- TIME_START=900 with TIME=1000: CMD_LATE=1 next cycle, no IMP, REQ_COMM pulse follows.
- Ti=80, Tp=50, N=2: IMP continuously high for 100 cycles. Tp=0 gives tp=1.
- Second DATA_WR during RUN (PEND_EN=1):
  - The second command starts without a REQ_COMM pulse.
  - Repeat with PEND_EN=0: the second command is dropped.
- rst_n low during RUN, then released: IMP=0, STATE=0, BUSY=0 immediately. No REQ_COMM until the next DATA_WR completes.
- CMD_SEARCH_FAULT=1 at train end: no REQ_COMM, STATE returns to 0.
